fetch_queue: RTL

//   Parametrised instruction prefetch queue between the bus-side fetch path and decode.

---
 rtl/fetch_queue.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue with redirect and epoch tagging
module fetch_queue #(
  parameter int XLEN  = 64,
  parameter int IW    = 32,
  parameter int DEPTH = 4,
  parameter int EPW   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       trap_en,
  input  logic [XLEN-1:0]            trap_pc,
  input  logic                       bj_en,
  input  logic [XLEN-1:0]            bj_pc,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [IW-1:0]              in_inst,
  input  logic [EPW-1:0]             in_epoch,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [IW-1:0]              out_inst,
  output logic                       redirect_en,
  output logic [XLEN-1:0]            redirect_pc,
  output logic [EPW-1:0]             cur_epoch,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [IW-1:0]   inst_mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  logic flush;
  logic full;
  logic epoch_ok;
  logic push;
  logic pop;

  // Handshake qualifiers; a flush cycle swallows any push or pop
  always_comb begin
    flush     = clear | trap_en | bj_en;
    full      = (count == CW'(DEPTH));
    in_ready  = !full;
    out_valid = (count != '0);
    epoch_ok  = (in_epoch == cur_epoch);
    push      = in_valid & in_ready & epoch_ok & !flush;
    pop       = out_valid & out_ready & !flush;
  end

  // Head of the queue is presented straight from storage, no bypass
  always_comb begin
    out_pc   = pc_mem[rd_ptr];
    out_inst = inst_mem[rd_ptr];
  end

  // Entry storage; cleared on reset so the head reads zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Redirect pulse and target; trap beats branch/jump, clear alone redirects nowhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_en <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect_en <= trap_en | bj_en;
      if (trap_en) begin
        redirect_pc <= trap_pc;
      end else if (bj_en) begin
        redirect_pc <= bj_pc;
      end
    end
  end

  // Every flush opens a new epoch so responses requested before it are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_epoch <= '0;
    end else if (flush) begin
      cur_epoch <= cur_epoch + EPW'(1);
    end
  end

endmodule
